mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported 32-bit memory between instruction fetch (port A) and
//  data access (port B). Round-robin arbiter with per-transaction ownership,
//  a variable-latency memory handshake and a stall timeout.
//  Drives the select of Mux32Bit2To1 instances that steer address and write data.
// PARAMETERS
//  TIMEOUT   16  max cycles waiting for mem_ready before abort (>=2)
//  FIRST_B   0   owner preferred on first arbitration after reset (0=A, 1=B)
// PORTS
//  Clk         in   1   single clock, rising edge
//  Reset_n     in   1   asynchronous, active-low reset
//  a_req       in   1   port A request; held with a_addr until a_done/a_err
//  a_addr      in   32  port A address
//  a_done      out  1   1-cycle pulse: A transaction complete, a_rdata valid
//  a_err       out  1   1-cycle pulse: A transaction aborted by timeout
//  a_rdata     out  32  read data for A, registered, held until next A done
//  b_req       in   1   port B request; held with b_addr/b_we/b_wdata until done/err
//  b_addr      in   32  port B address
//  b_we        in   1   port B write enable
//  b_wdata     in   32  port B write data
//  b_done      out  1   1-cycle pulse: B transaction complete
//  b_err       out  1   1-cycle pulse: B transaction aborted by timeout
//  b_rdata     out  32  read data for B, registered, held until next B done
//  mem_en      out  1   memory access strobe, high for whole access
//  mem_we      out  1   memory write enable (0 whenever owner is A)
//  mem_addr    out  32  muxed address
//  mem_wdata   out  32  muxed write data
//  mem_rdata   in   32  memory read data, valid when mem_ready=1
//  mem_ready   in   1   memory completes current access this cycle
//  mux_sel     out  1   owner select: 0=A, 1=B; also exported to datapath muxes
// BEHAVIOUR
//  Reset (async, Reset_n=0): state IDLE, mem_en=0, mem_we=0, all done/err=0,
//   a_rdata=b_rdata=0, timeout count=0, mux_sel=FIRST_B, last_owner=~FIRST_B.
//  States: IDLE, OWN_A, OWN_B.
//  IDLE: sample requests. Only one -> grant it. Both -> grant the one that is not
//   last_owner. Grant takes effect next edge; mem_en rises in OWN_x state.
//  OWN_x: mem_en=1, mux_sel fixed for whole access, count increments each cycle.
//   mem_ready=1 -> capture mem_rdata into x_rdata, pulse x_done next cycle,
//   last_owner<=x; if other port requesting go directly to OWN_other (back-to-back,
//   mem_en stays 1, no idle bubble), else IDLE.
//   count reaches TIMEOUT-1 without mem_ready -> pulse x_err, no rdata update,
//   last_owner<=x, return to IDLE (mem_en low >=1 cycle).
//  Latency: req high in IDLE at edge N -> mem_en high after edge N+1;
//   mem_ready at edge M -> x_done high in cycle after M.
//  mem_ready while IDLE is ignored. Deasserting x_req mid-transaction does not
//   abort; access completes and done still pulses. Requester must see done/err
//   before a new request; a req still high in the done cycle is a new request.
//  mux_sel holds last owner value while IDLE (no glitching on mem_addr).
//  mem_we = b_we only in OWN_B; A never writes.
//  Reset asserted mid-access: immediate return to IDLE, no done/err pulses.
// STRUCTURE
//  Shared header mem_arb_defs.vh: state encodings (IDLE=2'd0, OWN_A=2'd1,
//   OWN_B=2'd2), OWNER_A/OWNER_B select constants.
//  Sub-module: two Mux32Bit2To1 instances (address, write data) selected by mux_sel;
//   FSM, timeout counter and rdata capture registers live in this module.
// TESTING
//  Reset: Reset_n=0 mid-cycle -> all outputs at reset values without a clock edge.
//  A only: a_req=1, a_addr=0x00400000, mem_ready 2 cycles later, rdata=0x8C080004
//   -> mux_sel=0, a_done one cycle, a_rdata=0x8C080004, state back to IDLE.
//  Contention: a_req,b_req both 1 from reset (FIRST_B=0), ready=1 each access
//   -> grants A,B,A,B back-to-back, mem_en never drops, done pulses alternate.
//  B write: b_we=1, b_addr=0x10010000, b_wdata=0xDEADBEEF -> mem_we=1, mem_addr and
//   mem_wdata match for full access, b_done pulses, b_rdata unchanged from capture.
//  Timeout: TIMEOUT=16, mem_ready held 0 -> a_err pulses exactly 16 cycles after
//   mem_en rises, a_done never pulses, next grant goes to B if pending.
//  Abort: Reset_n low during OWN_B -> mem_en=0 at once, no b_done/b_err ever.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state encodings, owner select
// constants and the round-robin owner choice.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // With both ports requesting, the port that did not own the memory last wins.
    function automatic logic pick_owner(
        input logic a_req,
        input logic b_req,
        input logic last_owner
    );
        if (a_req && b_req) begin
            return ~last_owner;
        end
        return b_req ? OWNER_B : OWNER_A;
    endfunction

    function automatic logic [1:0] owner_state(input logic owner);
        return (owner == OWNER_B) ? ST_OWN_B : ST_OWN_A;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit 2:1 datapath mux steered by the arbiter owner select.
module Mux32Bit2To1
    import mem_port_arbiter_pkg::*;
(
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        sel,
    output logic [31:0] out_y
);

    assign out_y = (sel == OWNER_B) ? in_b : in_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// (port A) and data access (port B), with variable-latency handshake and timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter logic        FIRST_B = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic        a_done,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic        b_we,
    input  logic [31:0] b_wdata,
    output logic        b_done,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mux_sel
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             mux_sel_q, mux_sel_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_done_q, a_done_d;
    logic             a_err_q, a_err_d;
    logic             b_done_q, b_done_d;
    logic             b_err_q, b_err_d;
    logic [31:0]      a_rdata_q, a_rdata_d;
    logic [31:0]      b_rdata_q, b_rdata_d;

    logic own_a;
    logic own_b;
    logic other_req;
    logic grant_owner;

    assign own_a       = (state_q == ST_OWN_A);
    assign own_b       = (state_q == ST_OWN_B);
    assign other_req   = own_b ? a_req : b_req;
    assign grant_owner = pick_owner(a_req, b_req, last_owner_q);

    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        a_done_d     = 1'b0;
        a_err_d      = 1'b0;
        b_done_d     = 1'b0;
        b_err_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // mem_ready is ignored here; mux_sel keeps the last owner until a grant.
                if (a_req || b_req) begin
                    state_d   = owner_state(grant_owner);
                    mux_sel_d = grant_owner;
                    cnt_d     = '0;
                end
            end

            ST_OWN_A, ST_OWN_B: begin
                if (mem_ready) begin
                    if (own_b) begin
                        b_rdata_d = mem_rdata;
                        b_done_d  = 1'b1;
                    end else begin
                        a_rdata_d = mem_rdata;
                        a_done_d  = 1'b1;
                    end
                    last_owner_d = own_b;
                    cnt_d        = '0;
                    // Hand straight over to a waiting port so mem_en never drops.
                    if (other_req) begin
                        state_d   = owner_state(~own_b);
                        mux_sel_d = ~own_b;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    if (own_b) begin
                        b_err_d = 1'b1;
                    end else begin
                        a_err_d = 1'b1;
                    end
                    last_owner_d = own_b;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            mux_sel_q    <= FIRST_B;
            last_owner_q <= ~FIRST_B;
            cnt_q        <= '0;
            a_done_q     <= 1'b0;
            a_err_q      <= 1'b0;
            b_done_q     <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            a_done_q     <= a_done_d;
            a_err_q      <= a_err_d;
            b_done_q     <= b_done_d;
            b_err_q      <= b_err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign mem_en  = own_a | own_b;
    assign mem_we  = own_b & b_we;
    assign mux_sel = mux_sel_q;
    assign a_done  = a_done_q;
    assign a_err   = a_err_q;
    assign b_done  = b_done_q;
    assign b_err   = b_err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

    Mux32Bit2To1 u_addr_mux (
        .in_a  (a_addr),
        .in_b  (b_addr),
        .sel   (mux_sel_q),
        .out_y (mem_addr)
    );

    // Port A never writes, so its write-data leg is tied off.
    Mux32Bit2To1 u_wdata_mux (
        .in_a  ('0),
        .in_b  (b_wdata),
        .sel   (mux_sel_q),
        .out_y (mem_wdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected done/err pulses.
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        a_req;
    logic [31:0] a_addr;
    logic        a_done;
    logic        a_err;
    logic [31:0] a_rdata;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_we;
    logic [31:0] b_wdata;
    logic        b_done;
    logic        b_err;
    logic [31:0] b_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mux_sel;

    typedef struct packed {
        logic        port_b;
        logic        err;
        logic [31:0] rdata;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] a_model = '0;
    logic [31:0] b_model = '0;

    mem_port_arbiter #(
        .TIMEOUT (16),
        .FIRST_B (1'b0)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_done    (a_done),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_we      (b_we),
        .b_wdata   (b_wdata),
        .b_done    (b_done),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mux_sel   (mux_sel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic port_b, input logic err, input logic [31:0] rdata);
        sb_entry_t e;
        if (!err) begin
            if (port_b) b_model = rdata;
            else        a_model = rdata;
        end
        e.port_b = port_b;
        e.err    = err;
        e.rdata  = err ? (port_b ? b_model : a_model) : rdata;
        sb.push_back(e);
    endtask

    task automatic check_pulse(input logic port_b, input logic err, input logic [31:0] rdata);
        sb_entry_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fails++;
            $error("FAIL sb_unexpected: observed pulse port_b=%0b err=%0b expected none", port_b, err);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_port", {31'b0, port_b}, {31'b0, e.port_b});
            chk("sb_err", {31'b0, err}, {31'b0, e.err});
            chk("sb_rdata", rdata, e.rdata);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n === 1'b1) begin
            if (a_done === 1'b1 || a_err === 1'b1) check_pulse(1'b0, a_err, a_rdata);
            if (b_done === 1'b1 || b_err === 1'b1) check_pulse(1'b1, b_err, b_rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n   = 1'b1;
        a_req     = 1'b0;
        a_addr    = '0;
        b_req     = 1'b0;
        b_addr    = '0;
        b_we      = 1'b0;
        b_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Asynchronous reset seen before any clock edge.
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_b_done", b_done, 0);
        chk("rst_b_err", b_err, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_mux_sel", mux_sel, 0);

        // Contention from reset: both requesting, memory always ready.
        a_req     = 1'b1;
        a_addr    = 32'h0000_0100;
        b_req     = 1'b1;
        b_addr    = 32'h0000_0200;
        mem_ready = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("cont_mem_en", mem_en, 1);
            chk("cont_mux_sel", mux_sel, (i % 2));
            chk("cont_mem_addr", mem_addr, (i % 2) ? 32'h0000_0200 : 32'h0000_0100);
            mem_rdata = 32'hC0DE_0000 + 32'(i);
            push((i % 2) == 1, 1'b0, mem_rdata);
            if (i == 3) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
        @(negedge Clk);
        chk("cont_end_mem_en", mem_en, 0);
        chk("idle_hold_mux_sel", mux_sel, 1);
        mem_ready = 1'b0;

        // Port A read, memory ready two cycles after the grant.
        @(negedge Clk);
        a_req  = 1'b1;
        a_addr = 32'h0040_0000;
        @(negedge Clk);
        chk("a_mem_en", mem_en, 1);
        chk("a_mux_sel", mux_sel, 0);
        chk("a_mem_addr", mem_addr, 32'h0040_0000);
        chk("a_mem_we", mem_we, 0);
        @(negedge Clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h8C08_0004;
        push(1'b0, 1'b0, mem_rdata);
        @(negedge Clk);
        chk("a_done", a_done, 1);
        chk("a_rdata", a_rdata, 32'h8C08_0004);
        chk("a_back_idle", mem_en, 0);
        a_req     = 1'b0;
        mem_ready = 1'b0;
        @(negedge Clk);
        chk("a_done_width", a_done, 0);
        chk("a_idle_mux_sel", mux_sel, 0);

        // Port B write; request withdrawn mid-access must not abort it.
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 32'h1001_0000;
        b_wdata = 32'hDEAD_BEEF;
        @(negedge Clk);
        chk("bw_mem_en", mem_en, 1);
        chk("bw_mux_sel", mux_sel, 1);
        chk("bw_mem_we", mem_we, 1);
        chk("bw_mem_addr", mem_addr, 32'h1001_0000);
        chk("bw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        b_req = 1'b0;
        @(negedge Clk);
        chk("bw_held_en", mem_en, 1);
        chk("bw_held_we", mem_we, 1);
        chk("bw_held_addr", mem_addr, 32'h1001_0000);
        chk("bw_held_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        push(1'b1, 1'b0, mem_rdata);
        @(negedge Clk);
        chk("bw_done", b_done, 1);
        chk("bw_rdata", b_rdata, 32'h1234_5678);
        chk("bw_idle_we", mem_we, 0);
        chk("bw_idle_en", mem_en, 0);
        mem_ready = 1'b0;
        b_we      = 1'b0;

        // Port A timeout with B pending behind it.
        @(negedge Clk);
        a_req  = 1'b1;
        a_addr = 32'h0040_0010;
        @(negedge Clk);
        chk("to_mem_en", mem_en, 1);
        b_req  = 1'b1;
        b_addr = 32'h1001_0040;
        for (int k = 1; k < 16; k++) begin
            @(negedge Clk);
            chk("to_wait_en", mem_en, 1);
            chk("to_wait_err", a_err, 0);
            chk("to_wait_done", a_done, 0);
            if (k == 15) push(1'b0, 1'b1, 32'h0);
        end
        @(negedge Clk);
        chk("to_a_err", a_err, 1);
        chk("to_a_done", a_done, 0);
        chk("to_idle_en", mem_en, 0);
        @(negedge Clk);
        chk("to_next_en", mem_en, 1);
        chk("to_next_sel", mux_sel, 1);
        chk("to_next_addr", mem_addr, 32'h1001_0040);
        a_req = 1'b0;

        // Reset during the B access: immediate abort, no pulses afterwards.
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_b_done", b_done, 0);
        chk("abort_b_err", b_err, 0);
        chk("abort_mux_sel", mux_sel, 0);
        chk("abort_a_rdata", a_rdata, 0);
        b_req = 1'b0;
        a_model = '0;
        b_model = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            chk("post_abort_b_done", b_done, 0);
            chk("post_abort_b_err", b_err, 0);
            chk("post_abort_en", mem_en, 0);
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
